game_sequencer: RTL and testbench

Top-level controller for the memory-pattern game. It plays back the stored key pattern on the LEDs for the current stage, then collects player key presses and checks each one against the pattern. It issues a per-key correct pulse, a stage-clear pulse, a game-over fail and a final all-clear, and grows the stage length from 1 to NUM_STAGES. It owns stage progression; the display and key-debounce blocks sit around it.

---
 rtl/game_pkg.sv | 26 ++
 rtl/phase_timer.sv | 35 +++
 rtl/game_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the memory-pattern game controller.
package game_pkg;

    localparam int unsigned NUM_STAGES_DEF = 5;
    localparam int unsigned KEY_W_DEF      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW_ON,
        ST_SHOW_GAP,
        ST_WAIT_IN,
        ST_DONE,
        ST_FAILED
    } state_e;

    // One-hot LED word for a key index; caller truncates to the LED count.
    function automatic logic [31:0] onehot_key(input int unsigned key);
        return 32'd1 << key;
    endfunction

    // Thermometer mask with the low len bits set.
    function automatic logic [31:0] thermometer(input int unsigned len);
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; done_c is high in the last cycle of a loaded phase.
module phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load of N keeps the phase alive for exactly N cycles, N=1 included.
    assign done_c = (count_q == W'(1));

endmodule

// File: rtl/game_sequencer.sv
// Memory-pattern game controller: plays the pattern back on the LEDs, then
// checks player keys against it and advances the stage length.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
    parameter int unsigned KEY_W      = KEY_W_DEF,
    parameter int unsigned SHOW_TICKS = 50_000_000,
    parameter int unsigned GAP_TICKS  = 12_500_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_STAGES*KEY_W-1:0] pattern,
    input  logic                        key_valid,
    input  logic [KEY_W-1:0]            key_code,
    output logic [(1<<KEY_W)-1:0]       led,
    output logic [NUM_STAGES-1:0]       stage,
    output logic                        busy,
    output logic                        true_pulse,
    output logic                        clear,
    output logic                        allclear,
    output logic                        fail
);

    localparam int unsigned LEDS     = 1 << KEY_W;
    localparam int unsigned LEN_W    = $clog2(NUM_STAGES + 1);
    localparam int unsigned TICK_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int unsigned TMR_W    = $clog2(TICK_MAX + 1);

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      idx_q, idx_d;
    logic [LEDS-1:0]       led_q, led_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  busy_q, busy_d;
    logic                  true_pulse_q, true_pulse_d;
    logic                  clear_q, clear_d;
    logic                  allclear_q, allclear_d;
    logic                  fail_q, fail_d;

    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_value;
    logic                  tmr_done_c;

    // Pattern step selected with constant slices so an out-of-range index reads as zero.
    function automatic logic [KEY_W-1:0] step_at(input logic [NUM_STAGES*KEY_W-1:0] pat,
                                                 input logic [LEN_W-1:0] i);
        logic [KEY_W-1:0] key;
        key = '0;
        for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            if (i == LEN_W'(s)) begin
                key = pat[s*KEY_W +: KEY_W];
            end
        end
        return key;
    endfunction

    phase_timer #(
        .W (TMR_W)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done_c     (tmr_done_c)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        allclear_d   = allclear_q;
        fail_d       = fail_q;
        true_pulse_d = 1'b0;
        clear_d      = 1'b0;
        tmr_load     = 1'b0;
        tmr_value    = '0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAILED: begin
                if (start) begin
                    len_d      = LEN_W'(1);
                    idx_d      = '0;
                    allclear_d = 1'b0;
                    fail_d     = 1'b0;
                    state_d    = ST_SHOW_GAP;
                    tmr_load   = 1'b1;
                    tmr_value  = TMR_W'(GAP_TICKS);
                end
            end
            ST_SHOW_ON: begin
                if (tmr_done_c) begin
                    idx_d     = idx_q + LEN_W'(1);
                    state_d   = ST_SHOW_GAP;
                    tmr_load  = 1'b1;
                    tmr_value = TMR_W'(GAP_TICKS);
                end
            end
            ST_SHOW_GAP: begin
                if (tmr_done_c) begin
                    if (idx_q < len_q) begin
                        state_d   = ST_SHOW_ON;
                        tmr_load  = 1'b1;
                        tmr_value = TMR_W'(SHOW_TICKS);
                    end else begin
                        idx_d   = '0;
                        state_d = ST_WAIT_IN;
                    end
                end
            end
            ST_WAIT_IN: begin
                if (key_valid) begin
                    if (key_code == step_at(pattern, idx_q)) begin
                        true_pulse_d = 1'b1;
                        if (idx_q == len_q - LEN_W'(1)) begin
                            if (len_q < LEN_W'(NUM_STAGES)) begin
                                clear_d   = 1'b1;
                                len_d     = len_q + LEN_W'(1);
                                idx_d     = '0;
                                state_d   = ST_SHOW_GAP;
                                tmr_load  = 1'b1;
                                tmr_value = TMR_W'(GAP_TICKS);
                            end else begin
                                allclear_d = 1'b1;
                                state_d    = ST_DONE;
                            end
                        end else begin
                            idx_d = idx_q + LEN_W'(1);
                        end
                    end else begin
                        fail_d  = 1'b1;
                        state_d = ST_FAILED;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs follow the next state so they line up with the registered state.
        led_d   = (state_d == ST_SHOW_ON) ? LEDS'(onehot_key(32'(step_at(pattern, idx_d)))) : '0;
        busy_d  = (state_d == ST_SHOW_ON) || (state_d == ST_SHOW_GAP) || (state_d == ST_WAIT_IN);
        stage_d = NUM_STAGES'(thermometer(32'(len_d)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            led_q        <= '0;
            stage_q      <= '0;
            busy_q       <= 1'b0;
            true_pulse_q <= 1'b0;
            clear_q      <= 1'b0;
            allclear_q   <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            led_q        <= led_d;
            stage_q      <= stage_d;
            busy_q       <= busy_d;
            true_pulse_q <= true_pulse_d;
            clear_q      <= clear_d;
            allclear_q   <= allclear_d;
            fail_q       <= fail_d;
        end
    end

    assign led        = led_q;
    assign stage      = stage_q;
    assign busy       = busy_q;
    assign true_pulse = true_pulse_q;
    assign clear      = clear_q;
    assign allclear   = allclear_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed plus randomized bench for game_sequencer against a playback-queue model.
module tb_game_sequencer;

    localparam int unsigned NS   = 5;
    localparam int unsigned KW   = 2;
    localparam int unsigned NL   = 1 << KW;
    localparam int unsigned SHOW = 4;
    localparam int unsigned GAP  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_INPUT = 2;
    localparam int M_DONE  = 3;
    localparam int M_FAIL  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [NS*KW-1:0] pattern;
    logic             key_valid;
    logic [KW-1:0]    key_code;
    logic [NL-1:0]    led;
    logic [NS-1:0]    stage;
    logic             busy;
    logic             true_pulse;
    logic             clear;
    logic             allclear;
    logic             fail;

    always #5 clk = ~clk;

    game_sequencer #(
        .NUM_STAGES (NS),
        .KEY_W      (KW),
        .SHOW_TICKS (SHOW),
        .GAP_TICKS  (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .led        (led),
        .stage      (stage),
        .busy       (busy),
        .true_pulse (true_pulse),
        .clear      (clear),
        .allclear   (allclear),
        .fail       (fail)
    );

    int pat [NS] = '{0, 3, 1, 2, 1};
    int play_q [$];
    int m_mode, m_len, m_idx, m_led, m_tp, m_clr, m_ac, m_fail;
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int clr_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    endtask

    // Expected LED word per cycle for one full playback of the current stage.
    function automatic void build_play();
        play_q.delete();
        repeat (GAP) play_q.push_back(0);
        for (int i = 0; i < m_len; i++) begin
            repeat (SHOW) play_q.push_back(1 << pat[i]);
            repeat (GAP) play_q.push_back(0);
        end
    endfunction

    function automatic void model_edge(input bit rst, input bit st, input bit kv, input int kc);
        m_tp  = 0;
        m_clr = 0;
        m_led = 0;
        if (rst) begin
            m_mode = M_IDLE; m_len = 0; m_idx = 0; m_ac = 0; m_fail = 0;
            play_q.delete();
        end else if (m_mode == M_IDLE || m_mode == M_DONE || m_mode == M_FAIL) begin
            if (st) begin
                m_len = 1; m_idx = 0; m_ac = 0; m_fail = 0;
                build_play();
                m_led  = play_q.pop_front();
                m_mode = M_PLAY;
            end
        end else if (m_mode == M_PLAY) begin
            if (play_q.size() > 0) begin
                m_led = play_q.pop_front();
            end else begin
                m_mode = M_INPUT;
                m_idx  = 0;
            end
        end else if (kv) begin
            if (kc == pat[m_idx]) begin
                m_tp = 1;
                if (m_idx == m_len - 1) begin
                    if (m_len < NS) begin
                        m_clr = 1;
                        m_len = m_len + 1;
                        m_idx = 0;
                        build_play();
                        m_led  = play_q.pop_front();
                        m_mode = M_PLAY;
                    end else begin
                        m_ac   = 1;
                        m_mode = M_DONE;
                    end
                end else begin
                    m_idx = m_idx + 1;
                end
            end else begin
                m_fail = 1;
                m_mode = M_FAIL;
            end
        end
    endfunction

    task automatic cyc_step(input bit rst, input bit st, input bit kv, input int kc);
        reset     = rst;
        start     = st;
        key_valid = kv;
        key_code  = KW'(kc);
        @(posedge clk);
        model_edge(rst, st, kv, kc);
        #1;
        cyc = cyc + 1;
        if (clear === 1'b1) clr_seen = clr_seen + 1;
        chk("led",        32'(led),        32'(m_led));
        chk("busy",       32'(busy),       32'((m_mode == M_PLAY) || (m_mode == M_INPUT)));
        chk("stage",      32'(stage),      32'((1 << m_len) - 1));
        chk("true_pulse", 32'(true_pulse), 32'(m_tp));
        chk("clear",      32'(clear),      32'(m_clr));
        chk("allclear",   32'(allclear),   32'(m_ac));
        chk("fail",       32'(fail),       32'(m_fail));
    endtask

    // Playback with ignored key/start noise; bounded in cycles.
    task automatic run_until_input(input int budget);
        int k;
        k = 0;
        while (m_mode == M_PLAY && k < budget) begin
            cyc_step(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                     int'($urandom_range(0, NL - 1)));
            k = k + 1;
        end
        if (m_mode == M_PLAY) chk("play_timeout", 32'(busy), 32'(0));
    endtask

    task automatic press(input int kc);
        cyc_step(1'b0, 1'b0, 1'b1, kc);
        repeat ($urandom_range(0, 2)) cyc_step(1'b0, (m_mode == M_INPUT) && ($urandom_range(0, 1) == 1), 1'b0, 0);
    endtask

    task automatic play_stages_correct(input int n);
        for (int l = 1; l <= n; l++) begin
            run_until_input(200);
            for (int i = 0; i < l; i++) press(pat[i]);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        key_valid = 1'b0;
        key_code  = '0;
        pattern   = {2'd1, 2'd2, 2'd1, 2'd3, 2'd0};
        m_mode = M_IDLE; m_len = 0; m_idx = 0; m_led = 0;
        m_tp = 0; m_clr = 0; m_ac = 0; m_fail = 0;

        // Reset state, then a full winning game
        cyc_step(1'b1, 1'b0, 1'b0, 0);
        cyc_step(1'b1, 1'b0, 1'b0, 0);
        cyc_step(1'b0, 1'b0, 1'b1, 1);
        clr_seen = 0;
        cyc_step(1'b0, 1'b1, 1'b0, 0);
        play_stages_correct(NS);
        repeat (3) cyc_step(1'b0, 1'b0, 1'b0, 0);
        press(2);
        repeat (2) cyc_step(1'b0, 1'b0, 1'b0, 0);
        chk("clear_count", 32'(clr_seen), 32'(NS - 1));

        // Wrong key in stage 3, then restart
        cyc_step(1'b0, 1'b1, 1'b0, 0);
        play_stages_correct(2);
        run_until_input(200);
        press(0);
        press(2);
        repeat (3) cyc_step(1'b0, 1'b0, 1'b1, 3);
        cyc_step(1'b0, 1'b1, 1'b0, 0);
        run_until_input(200);
        press(pat[0]);

        // Reset during SHOW_ON of stage 2
        for (int k = 0; k < 50 && m_led == 0; k++) cyc_step(1'b0, 1'b0, 1'b0, 0);
        cyc_step(1'b1, 1'b0, 1'b0, 0);
        cyc_step(1'b0, 1'b0, 1'b0, 0);

        // Reset during WAIT_IN of stage 4
        cyc_step(1'b0, 1'b1, 1'b0, 0);
        play_stages_correct(3);
        run_until_input(200);
        press(pat[0]);
        cyc_step(1'b1, 1'b0, 1'b0, 0);
        cyc_step(1'b0, 1'b1, 1'b0, 0);
        run_until_input(200);
        press(pat[0]);
        run_until_input(200);

        // Randomized games with occasional wrong keys
        repeat (4) begin
            cyc_step(1'b0, 1'b1, 1'b0, 0);
            for (int l = 1; l <= NS && m_mode != M_FAIL; l++) begin
                run_until_input(200);
                for (int i = 0; i < l && m_mode == M_INPUT; i++) begin
                    if ($urandom_range(0, 11) == 0) press(int'($urandom_range(0, NL - 1)));
                    else press(pat[i]);
                end
            end
            repeat (2) cyc_step(1'b0, 1'b0, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
